// File: rtl/req_capture_encoder.sv
// Request capture stage: detects events on raw request lines, holds them sticky in
// a pending register and serves them highest-index first through a valid/ready slot.
module req_capture_encoder #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 3,
  parameter int unsigned EDGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         clr_all,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [N-1:0] d_q;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic         overflow_q, overflow_d;

  logic [N-1:0] ev;
  logic [N-1:0] mv;
  logic [W-1:0] sel;
  logic         free;
  logic         any_pending;
  logic         load;

  // Event source: rising edges against the history register, or the raw level.
  assign ev = (EDGE != 0) ? (d & ~d_q) : d;

  // Highest set pending bit wins; later iterations overwrite lower indices.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_q[i]) sel = W'(i);
    end
  end

  assign free        = ~valid_q | ready;
  assign any_pending = |pending_q;
  assign load        = free & any_pending;
  assign mv          = load ? (N'(1) << sel) : '0;

  always_comb begin
    pending_d  = pending_q;
    y_d        = y_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (clr_all) begin
      pending_d  = '0;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (free) begin
        valid_d = any_pending;
        if (any_pending) y_d = sel;
      end
      // A fresh event on the bit leaving this edge simply re-arms it.
      pending_d  = (pending_q & ~mv) | ev;
      overflow_d = overflow_q | (|(ev & pending_q & ~mv));
    end
  end

  always_ff @(posedge clk) begin
    d_q <= d;
    if (rst) begin
      pending_q  <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign y        = y_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_capture_encoder.sv
// Directed bench for req_capture_encoder: edge-mode instance with a scoreboard on
// accepted codes, plus a level-mode instance for reset/re-arm behaviour.
module tb_req_capture_encoder;

  logic       clk;
  logic       rst1, clr1, ready1;
  logic [7:0] d1;
  logic [2:0] y1;
  logic       valid1, overflow1;
  logic [7:0] pending1;

  logic       rst0, clr0, ready0;
  logic [7:0] d0;
  logic [2:0] y0;
  logic       valid0, overflow0;
  logic [7:0] pending0;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb1[$];

  req_capture_encoder #(.N(8), .W(3), .EDGE(1)) u_edge (
    .clk(clk), .rst(rst1), .d(d1), .clr_all(clr1), .y(y1), .valid(valid1),
    .ready(ready1), .pending(pending1), .overflow(overflow1)
  );

  req_capture_encoder #(.N(8), .W(3), .EDGE(0)) u_level (
    .clk(clk), .rst(rst0), .d(d0), .clr_all(clr0), .y(y0), .valid(valid0),
    .ready(ready0), .pending(pending0), .overflow(overflow0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer side: every accept pops the next expected code.
  always @(negedge clk) begin
    if (valid1 && ready1 && !rst1 && !clr1) begin
      if (sb1.size() == 0) chk("sb_extra", 32'(y1), 32'hFFFF_FFFF);
      else chk("sb_y", 32'(y1), 32'(sb1.pop_front()));
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] seq [4];
    seq[0] = 3'd7; seq[1] = 3'd6; seq[2] = 3'd3; seq[3] = 3'd0;

    rst1 = 1'b1; clr1 = 1'b0; ready1 = 1'b1; d1 = 8'h00;
    rst0 = 1'b1; clr0 = 1'b0; ready0 = 1'b1; d0 = 8'h00;
    tick(); tick();
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_y", 32'(y1), 32'd0);
    chk("rst_pending", 32'(pending1), 32'd0);
    chk("rst_overflow", 32'(overflow1), 32'd0);
    chk("rst_level_valid", 32'(valid0), 32'd0);
    rst1 = 1'b0;
    tick();

    // Single event
    d1 = 8'h01; sb1.push_back(3'd0);
    tick();
    chk("t1_pending", 32'(pending1), 32'h01);
    chk("t1_valid_early", 32'(valid1), 32'd0);
    tick();
    chk("t1_valid", 32'(valid1), 32'd1);
    chk("t1_y", 32'(y1), 32'd0);
    chk("t1_pending_after", 32'(pending1), 32'h00);
    tick();
    chk("t1_valid_drop", 32'(valid1), 32'd0);
    chk("t1_overflow", 32'(overflow1), 32'd0);
    d1 = 8'h00;
    tick();

    // Simultaneous events
    d1 = 8'hC9;
    for (int i = 0; i < 4; i++) sb1.push_back(seq[i]);
    tick();
    chk("t2_pending", 32'(pending1), 32'hC9);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_valid", 32'(valid1), 32'd1);
      chk("t2_y", 32'(y1), 32'(seq[i]));
    end
    tick();
    chk("t2_valid_drop", 32'(valid1), 32'd0);
    chk("t2_overflow", 32'(overflow1), 32'd0);
    d1 = 8'h00;
    tick();

    // Backpressure
    ready1 = 1'b0; d1 = 8'h24;
    sb1.push_back(3'd5); sb1.push_back(3'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid_hold", 32'(valid1), 32'd1);
      chk("t3_y_hold", 32'(y1), 32'd5);
      chk("t3_pending_hold", 32'(pending1), 32'h04);
    end
    ready1 = 1'b1;
    tick();
    chk("t3_y2", 32'(y1), 32'd2);
    chk("t3_valid2", 32'(valid1), 32'd1);
    tick();
    chk("t3_valid_drop", 32'(valid1), 32'd0);
    d1 = 8'h00;
    tick();

    // Overflow and re-arm
    ready1 = 1'b0; d1 = 8'h08; sb1.push_back(3'd3);
    tick(); tick();
    chk("t4_slot_y", 32'(y1), 32'd3);
    d1 = 8'h00; tick();
    d1 = 8'h08; sb1.push_back(3'd3); tick();
    chk("t4_no_ovf_yet", 32'(overflow1), 32'd0);
    d1 = 8'h00; tick();
    d1 = 8'h08; tick();
    chk("t4_overflow", 32'(overflow1), 32'd1);
    chk("t4_pending3", 32'(pending1), 32'h08);
    d1 = 8'h00; tick();
    ready1 = 1'b1; d1 = 8'h08; sb1.push_back(3'd3);
    tick();
    chk("t4_rearm_pending", 32'(pending1), 32'h08);
    chk("t4_rearm_overflow", 32'(overflow1), 32'd1);
    chk("t4_rearm_y", 32'(y1), 32'd3);
    d1 = 8'h00;
    tick();
    chk("t4_pending_clear", 32'(pending1), 32'h00);
    tick();
    chk("t4_valid_drop", 32'(valid1), 32'd0);
    chk("t4_sb_empty", 32'(sb1.size()), 32'd0);

    // Flush with a simultaneous rise that must be discarded
    ready1 = 1'b0; d1 = 8'hFF;
    tick(); tick();
    d1 = 8'h00; tick();
    d1 = 8'h80; tick();
    chk("t5_pre_pending", 32'(pending1), 32'hFF);
    chk("t5_pre_valid", 32'(valid1), 32'd1);
    chk("t5_pre_overflow", 32'(overflow1), 32'd1);
    chk("t5_pre_y", 32'(y1), 32'd7);
    clr1 = 1'b1; d1 = 8'h90;
    tick();
    chk("t5_pending", 32'(pending1), 32'h00);
    chk("t5_valid", 32'(valid1), 32'd0);
    chk("t5_overflow", 32'(overflow1), 32'd0);
    chk("t5_y_hold", 32'(y1), 32'd7);
    clr1 = 1'b0; ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_quiet_valid", 32'(valid1), 32'd0);
      chk("t5_quiet_pending", 32'(pending1), 32'h00);
    end
    d1 = 8'h00;
    tick();

    // Lines held high through reset: edge mode sees nothing
    rst1 = 1'b1; d1 = 8'hFF;
    tick(); tick();
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_edge_valid", 32'(valid1), 32'd0);
      chk("t6_edge_pending", 32'(pending1), 32'h00);
    end

    // Level mode: held lines present immediately and keep re-arming
    d0 = 8'hFF;
    tick();
    rst0 = 1'b0;
    tick();
    chk("t6_lvl_pending", 32'(pending0), 32'hFF);
    chk("t6_lvl_valid_early", 32'(valid0), 32'd0);
    tick();
    chk("t6_lvl_valid", 32'(valid0), 32'd1);
    chk("t6_lvl_y", 32'(y0), 32'd7);
    chk("t6_lvl_pending2", 32'(pending0), 32'hFF);
    chk("t6_lvl_overflow", 32'(overflow0), 32'd1);
    tick();
    chk("t6_lvl_y_again", 32'(y0), 32'd7);
    chk("t6_lvl_valid_again", 32'(valid0), 32'd1);

    chk("sb_empty_end", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_capture_encoder.md
Name: req_capture_encoder

Overview:
- Upstream capture stage for the 8-to-3 encoder path.
- Samples eight raw request lines and detects events on them (rising edge or level).
- Holds each event in a sticky pending register until it is served.
- Serves pending events one at a time, highest index first, as a registered 3-bit code with a valid/ready handshake. Simultaneous or back-to-back events are never lost or merged.

Parameters:
- N, 8, number of request lines.
- W, 3, code width; must equal clog2(N).
- EDGE, 1. 1 = capture rising edges of d; 0 = capture the level (bit set every cycle d is high).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  N  raw request lines; d[N-1] has highest priority.
- clr_all  input  1  synchronous flush of pending, output slot and overflow.
- y  output  W  encoded index of the event being presented.
- valid  output  1  y holds an unconsumed event.
- ready  input  1  consumer accepts y at an edge where valid=1 and ready=1.
- pending  output  N  current sticky pending register.
- overflow  output  1  sticky flag: an event arrived on a bit that was already pending.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, valid=0, y=0, overflow=0.
  - The d history register loads d, so lines already high at reset release do not register an event.
- Event detect:
  - ev = d & ~d_q when EDGE=1; ev = d when EDGE=0.
  - d_q <= d every edge, including edges where clr_all=1.
- Slot free: free = ~valid | ready.
- Selection:
  - sel = highest index i with pending[i]=1.
  - When free=1 and pending != 0, the slot loads at this edge: y <= sel, valid <= 1, and bit sel is removed from pending.
  - When free=1 and pending = 0: valid <= 0 and y holds its old value.
  - When free=0: y and valid hold, and y stays stable while valid=1 and ready=0.
- Pending update: pending <= (pending & ~mv) | ev, where mv is the one-hot of the bit moved this edge (0 if none).
  - A new event on the bit being moved this edge stays pending and is not an overflow.
- Overflow: set when (ev & pending & ~mv) != 0. It stays set until rst or clr_all.
- Latency (EDGE=1, idle block, ready=1):
  - d rises before edge k: pending bit set after edge k.
  - valid=1 and y=index after edge k+1. Two cycles from the sampled edge to presentation.
- Events are sampled only from pending, never bypassed directly from ev. This keeps the path registered.
- Throughput: one event per cycle while ready=1 and pending is non-empty.
- Starvation: a low-index bit waits while higher bits keep re-arming. This is accepted behaviour and the block does no fairness rotation.
- clr_all (rst=0):
  - At the edge: pending=0, valid=0, overflow=0; y holds.
  - Events detected on that same edge are discarded.
- Priority of controls: rst > clr_all > normal operation.
- Reset or clr_all during a stalled handshake (valid=1, ready=0) drops the presented event; no accept is signalled.
- With EDGE=0 and a held line, the bit re-arms every cycle:
  - Overflow sets whenever the bit is still pending and not moved.
  - The consumer sees the index repeatedly, once per accept.

Test Plan:
1. Single event: reset, then d=8'h01 held (EDGE=1, ready=1) → y=0, valid=1 for exactly one cycle, two cycles after the sampled edge. Then pending=0 and overflow=0.
2. Simultaneous events: d goes 8'h00→8'hC9 in one cycle, ready=1 → y sequence 7,6,3,0 on four consecutive cycles with valid=1, then valid=0. overflow=0.
3. Backpressure: pending holds bits 5 and 2, ready=0 for 5 cycles → valid=1 and y=5 stable throughout, pending=8'h04. After ready=1: y=2, then valid=0.
4. Overflow and re-arm:
   - Bit 3 pulses (rise, fall, rise) while the slot is stalled on bit 3's earlier event, ready=0 → overflow=1 and pending[3]=1.
   - A rise on bit 3 at the same edge it is moved into the slot → pending[3]=1 and overflow unchanged.
5. Flush: pending=8'hFF, valid=1, overflow=1, clr_all pulsed for one cycle with a simultaneous rise on d[4] → next cycle pending=0, valid=0, overflow=0, y unchanged. No event for bit 4 appears later.
6. Reset behaviour: d=8'hFF held through rst and after release (EDGE=1) → no events and valid stays 0. Repeat with EDGE=0 → y=7 presented two cycles after the first edge with rst=0.
